// File: rtl/router_out_arbiter.sv
// Per-destination output arbiter: round-robin packet ownership among four sources,
// a registered forwarding stage, and a small register window (enable mask, status, counters).
module router_out_arbiter #(
  parameter int          DW      = 8,
  parameter int          TIMEOUT = 16,
  parameter logic [7:0]  BASE    = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] src_data,
  input  logic [3:0]      src_valid,
  output logic [3:0]      grant,
  output logic [DW-1:0]   da,
  output logic            da_valid,
  input  logic            wr,
  input  logic            rd,
  input  logic [7:0]      addr,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [1:0]      owner, last, pick;
  logic            found;
  logic [3:0]      en_mask, eligible;
  logic            sticky;
  logic [7:0]      cnt [4];
  logic [TW-1:0]   tcount;
  logic            own_valid;
  logic [DW-1:0]   own_data;
  logic            timeout_hit, pkt_end;
  logic [7:0]      offset;
  logic [7:0]      rd_val;

  assign own_valid = src_valid[owner];
  assign own_data  = src_data[int'(owner)*DW +: DW];
  assign eligible  = req & en_mask;
  assign offset    = addr - BASE;

  // Arbitration, end-of-ownership detection and next state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found       = 1'b0;
    pick        = last;
    state_nxt   = state;
    // Search starts one past the previous owner so each source gets a turn.
    for (int k = 1; k <= 4; k++) begin
      if (!found && eligible[2'(last + 2'(k))]) begin
        found = 1'b1;
        pick  = 2'(last + 2'(k));
      end
    end
    timeout_hit = (state == WAIT) && !own_valid && (tcount == TW'(TIMEOUT - 1));
    pkt_end     = (state == XFER) && !own_valid;
    case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    if (own_valid) state_nxt = XFER;
               else if (timeout_hit) state_nxt = IDLE;
      XFER:    if (!own_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = 8'h00;
    case (offset)
      8'h00:   rd_val = {4'b0000, en_mask};
      8'h01:   rd_val = {4'b0000, sticky, (state != IDLE), owner};
      8'h02:   rd_val = cnt[0];
      8'h03:   rd_val = cnt[1];
      8'h04:   rd_val = cnt[2];
      8'h05:   rd_val = cnt[3];
      default: rd_val = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= 4'b0000;
      da       <= '0;
      da_valid <= 1'b0;
      owner    <= 2'd0;
      last     <= 2'd3;
      tcount   <= '0;
    end else begin
      da_valid <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner  <= pick;
          grant  <= 4'b0001 << pick;
          tcount <= '0;
        end
        WAIT: begin
          // The byte that ends the wait is already the first byte of the packet.
          if (own_valid) begin
            da       <= own_data;
            da_valid <= 1'b1;
          end else if (timeout_hit) begin
            grant <= 4'b0000;
            last  <= owner;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        XFER: begin
          if (own_valid) begin
            da       <= own_data;
            da_valid <= 1'b1;
          end else begin
            grant <= 4'b0000;
            last  <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  // Register window; a counter clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is a handful of flops, so it is reset like any other state.
      for (int i = 0; i < 4; i++) cnt[i] <= 8'h00;
      en_mask <= 4'hF;
      sticky  <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr && offset == 8'(i + 2))
          cnt[i] <= 8'h00;
        else if (pkt_end && owner == 2'(i))
          cnt[i] <= cnt[i] + 8'd1;
      end
      if (wr && offset == 8'h00) en_mask <= wdata[3:0];
      if (timeout_hit)
        sticky <= 1'b1;
      else if (wr && offset == 8'h01 && wdata[3])
        sticky <= 1'b0;
      if (rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: stimulus pushes expected bytes and read data into
// queues; a negedge monitor pops and compares whenever the DUT presents output.
module tb_router_out_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] src_data = '0;
  logic [3:0]  src_valid = 4'b0000;
  logic [3:0]  grant;
  logic [7:0]  da;
  logic        da_valid;
  logic        wr = 1'b0, rd = 1'b0;
  logic [7:0]  addr = 8'h00, wdata = 8'h00;
  logic [7:0]  rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_da [$];
  logic [7:0] exp_rd [$];
  bit rd_q = 1'b0;

  router_out_arbiter #(.DW(8), .TIMEOUT(16), .BASE(8'h00)) dut (
    .clk(clk), .reset(reset), .req(req), .src_data(src_data), .src_valid(src_valid),
    .grant(grant), .da(da), .da_valid(da_valid),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: destination stream and register read data.
  always @(posedge clk) rd_q <= rd;

  always @(negedge clk) begin
    if (da_valid) begin
      if (exp_da.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL da_unexpected: got %0h expected none at %0t", da, $time);
      end else begin
        check("da", da, exp_da.pop_front());
      end
    end
    if (rd_q) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rdata_unexpected: got %0h expected none at %0t", rdata, $time);
      end else begin
        check("rdata", rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; src_valid = '0; wr = 0; rd = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [7:0] exp);
    rd = 1'b1; addr = a;
    exp_rd.push_back(exp);
    tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    if (grant == 4'b0000) begin
      n_cmp++; n_err++;
      $display("FAIL grant_wait: got 0 expected a grant within 40 cycles at %0t", $time);
    end
  endtask

  // Waits for ownership, checks the owner, streams n bytes, checks release.
  task automatic send_packet(input int src, input int n, input logic [7:0] base);
    wait_grant();
    check("grant_owner", grant, 4'b0001 << src);
    for (int i = 0; i < n; i++) begin
      src_valid[src] = 1'b1;
      src_data[src*8 +: 8] = base + 8'(i);
      exp_da.push_back(base + 8'(i));
      tick();
    end
    src_valid[src] = 1'b0;
    tick();
    check("grant_release", grant, 4'b0000);
    check("da_valid_end", da_valid, 1'b0);
  endtask

  initial begin
    // Reset values.
    do_reset();
    check("rst_grant", grant, 4'b0000);
    check("rst_da_valid", da_valid, 1'b0);
    check("rst_da", da, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    reg_read(8'h00, 8'h0F);
    reg_read(8'h01, 8'h00);

    // Single packet from source 0, one-cycle grant latency.
    req = 4'b0001;
    tick();
    check("grant_latency", grant, 4'b0001);
    send_packet(0, 3, 8'hA1);
    req = 4'b0000;
    reg_read(8'h02, 8'h01);

    // Round robin with all sources requesting, from reset priority.
    do_reset();
    req = 4'b1111;
    for (int p = 0; p < 8; p++) send_packet(p % 4, 2, 8'(8'h10 * p));
    req = 4'b0000;
    for (int i = 0; i < 4; i++) reg_read(8'(2 + i), 8'h02);

    // Enable mask restricts arbitration to sources 1 and 3.
    reg_write(8'h00, 8'h0A);
    req = 4'b1111;
    send_packet(1, 1, 8'h51);
    send_packet(3, 1, 8'h53);
    send_packet(1, 1, 8'h61);
    send_packet(3, 1, 8'h63);
    req = 4'b0000;
    reg_write(8'h00, 8'h0F);

    // Source 2 never raises valid: grant revoked after 16 WAIT cycles.
    req = 4'b0100;
    tick();
    check("to_grant", grant, 4'b0100);
    req = 4'b0010;
    for (int i = 0; i < 15; i++) tick();
    check("to_still_held", grant, 4'b0100);
    tick();
    check("to_dropped", grant, 4'b0000);
    tick();
    check("to_next_grant", grant, 4'b0010);
    send_packet(1, 2, 8'h71);
    req = 4'b0000;
    tick();
    reg_read(8'h01, 8'h09);
    reg_read(8'h04, 8'h02);
    reg_write(8'h01, 8'h08);
    reg_read(8'h01, 8'h01);

    // Unmapped address and simultaneous read/write.
    reg_write(8'h07, 8'hFF);
    reg_read(8'h07, 8'h00);
    rd = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 8'h05;
    exp_rd.push_back(8'h0F);
    tick();
    rd = 1'b0; wr = 1'b0;
    tick();
    reg_read(8'h00, 8'h05);
    reg_write(8'h00, 8'h0F);

    // Reset during the second byte of a 4-byte packet.
    req = 4'b0010;
    wait_grant();
    src_valid[1] = 1'b1; src_data[15:8] = 8'hB0; exp_da.push_back(8'hB0);
    tick();
    src_data[15:8] = 8'hB1; exp_da.push_back(8'hB1);
    tick();
    src_data[15:8] = 8'hB2;
    reset = 1'b1;
    tick();
    check("rst_mid_grant", grant, 4'b0000);
    check("rst_mid_da_valid", da_valid, 1'b0);
    reset = 1'b0; src_valid = '0; req = 4'b0000;
    tick();
    reg_read(8'h03, 8'h00);
    req = 4'b1010;
    tick();
    check("rst_first_grant", grant, 4'b0010);
    send_packet(1, 2, 8'hC0);
    req = 4'b0000;

    // Counter wrap and clear-beats-increment.
    reg_write(8'h03, 8'h00);
    reg_read(8'h03, 8'h00);
    req = 4'b0010;
    for (int p = 0; p < 255; p++) send_packet(1, 1, 8'(p));
    req = 4'b0000;
    reg_read(8'h03, 8'hFF);
    req = 4'b0010;
    send_packet(1, 1, 8'hEE);
    req = 4'b0000;
    reg_read(8'h03, 8'h00);
    req = 4'b0010;
    send_packet(1, 1, 8'hEF);
    req = 4'b0000;
    reg_read(8'h03, 8'h01);
    req = 4'b0010;
    wait_grant();
    check("clr_grant", grant, 4'b0010);
    src_valid[1] = 1'b1; src_data[15:8] = 8'hF0; exp_da.push_back(8'hF0);
    tick();
    src_valid[1] = 1'b0; wr = 1'b1; addr = 8'h03; wdata = 8'h00;
    tick();
    wr = 1'b0; req = 4'b0000;
    tick();
    reg_read(8'h03, 8'h00);

    tick(); tick();
    check("da_queue_drained", exp_da.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-destination output arbiter for the 4x4 router. Four source ports compete for one destination port. The block grants ownership one packet at a time in round-robin order and forwards the owner's byte stream to the destination through a one-cycle register stage. A small register window on the router's wr/rd/addr/wdata/rdata bus provides a source enable mask, status, and per-source packet counters.

## Interface
- DW, 8, data width of source/destination bytes
- TIMEOUT, 16, cycles a granted source may leave its valid low before the grant is revoked
- BASE, 8'h00, base address of this arbiter's register window

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req  in  4  bit i: source i has a packet for this destination
- src_data  in  4*DW  source i data in bits [i*DW +: DW]
- src_valid  in  4  bit i: source i byte valid; stays high for the whole packet
- grant  out  4  one-hot owner, or 0 when idle
- da  out  DW  destination data
- da_valid  out  1  destination byte valid
- wr  in  1  register write strobe
- rd  in  1  register read strobe
- addr  in  8  register address
- wdata  in  8  write data
- rdata  out  8  read data, registered

## Operation
- State machine IDLE -> WAIT -> XFER -> IDLE.
- IDLE: eligible = req & en_mask. If eligible != 0, pick the first set bit searching from (last+1) mod 4 upward with wrap. Load owner and drive grant one-hot. Go to WAIT.
- WAIT: if src_valid[owner]=1, go to XFER. If TIMEOUT cycles pass in WAIT, clear grant, go to IDLE, update last=owner, and do not increment the counter.
- XFER: da <= src_data[owner] and da_valid <= src_valid[owner] every cycle. When src_valid[owner] samples 0, that is end of packet: clear grant, go to IDLE, set last=owner, cnt[owner]++ (8-bit, wraps 255->0).
- Non-owner src_valid/src_data are ignored. In IDLE and WAIT, da_valid=0 and da holds its last value.
- en_mask changes and req drops have no effect on the current owner. They apply only at the next IDLE arbitration.
- Registers (offset from BASE):
  - 0x0 CTRL[3:0]: en_mask, R/W, reset 4'hF.
  - 0x1 STATUS: [1:0] owner, [2] busy (state != IDLE), [3] timeout sticky; read-only, write of 1 to bit3 clears it.
  - 0x2..0x5: cnt[0..3], read; any write clears that counter.
  - Other addresses read 0, and writes to them are ignored.
- A counter write and an increment in the same cycle: the write (clear) wins.
- rd and wr in the same cycle to the same address: rdata returns the pre-write value.

## Timing
- Reset values: grant=0, da=0, da_valid=0, rdata=0, state=IDLE, last=3 (source 0 has first priority), cnt=0, en_mask=F, sticky=0.
- Reset asserted mid-packet: grant and da_valid are 0 at the edge following reset assertion. The partial packet is not counted.
- req sampled high at edge T -> grant high after edge T (visible in cycle T+1).
- In XFER, a src byte sampled at edge E appears on da/da_valid after edge E.
- Valid low sampled at edge E -> grant=0 and da_valid=0 after E. The earliest next grant comes after E+1, so there is at least one grant-low cycle between packets.
- WAIT timeout: grant drops after the TIMEOUT-th WAIT cycle edge.
- rdata is updated at the edge where rd=1 and holds its value otherwise.

## Test plan
- Reset, then req=4'b0001, source 0 sends 3 bytes A1,A2,A3 -> grant=0001 one cycle after req; da shows A1..A3 with a one-cycle lag; cnt0 reads 1.
- req=4'b1111 held, each source sends 2-byte packets -> grant order 0,1,2,3,0. Each source's cnt reaches the same value after 8 packets.
- en_mask written to 4'b1010 with req=1111 -> only sources 1 and 3 are granted, alternating.
- Source 2 granted but never raises valid -> grant drops after 16 cycles; STATUS bit3=1; cnt2 unchanged; the next requester is then granted.
- Reset asserted during the 2nd byte of a 4-byte packet -> after the next edge grant=0, da_valid=0, and cnt=0. The first grant after reset goes to the lowest requesting source.
- cnt1 preloaded to 255 by sending 255 packets, then one more packet -> reads 0. A write to 0x3 in the same cycle as an increment -> reads 0.
